// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Widths and types shared by the CDB arbiter, its interface and the
//   round-robin picker.
//   XLEN  : result width
//   ARN_W : architectural register number width
//   RRN_W : rename register number width
//   cdb_entry_t : one common-data-bus beat {valid, result, arn, rrn}
package cdb_arbiter_pkg;

   localparam int XLEN  = 32;
   localparam int ARN_W = 5;
   localparam int RRN_W = 6;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  result;
      logic [ARN_W-1:0] arn;
      logic [RRN_W-1:0] rrn;
   } cdb_entry_t;

   // Population count over up to 8 requesters (N_REQ <= 8).
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Requester handshake plus the two registered common data buses.
//   Parameter N_REQ : number of result requesters.
//   master : result producers / CDB consumers (drive req_*, see ready + cdb_*)
//   slave  : the arbiter (sees req_*, drives req_ready + cdb_*)
interface cdb_arbiter_if #(parameter int N_REQ = 4);
   import cdb_arbiter_pkg::*;

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0][XLEN-1:0]  req_result;
   logic [N_REQ-1:0][ARN_W-1:0] req_arn;
   logic [N_REQ-1:0][RRN_W-1:0] req_rrn;
   logic [N_REQ-1:0]            req_ready;

   logic [1:0]                  cdb_valid;
   logic [1:0][XLEN-1:0]        cdb_result;
   logic [1:0][ARN_W-1:0]       cdb_arn;
   logic [1:0][RRN_W-1:0]       cdb_rrn;

   modport master (
      output req_valid, req_result, req_arn, req_rrn,
      input  req_ready, cdb_valid, cdb_result, cdb_arn, cdb_rrn
   );

   modport slave (
      input  req_valid, req_result, req_arn, req_rrn,
      output req_ready, cdb_valid, cdb_result, cdb_arn, cdb_rrn
   );

endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational round-robin picker returning up to two grants per cycle.
//   Scan starts at ptr and walks upward modulo N; first hit -> gnt0,
//   second hit -> gnt1. ptr_nxt is one past the last grant, or ptr when
//   nothing is granted.
//   req     in  N   request vector
//   ptr     in  PW  scan start index (< N)
//   gnt0/1  out N   one-hot grants
//   vld0/1  out 1   grant present
//   ptr_nxt out PW  pointer for the next cycle
module rr_pick2 #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt0,
   output logic [N-1:0]  gnt1,
   output logic          vld0,
   output logic          vld1,
   output logic [PW-1:0] ptr_nxt
);

   always_comb begin
      int s;
      logic [PW-1:0] idx;
      gnt0    = '0;
      gnt1    = '0;
      vld0    = 1'b0;
      vld1    = 1'b0;
      ptr_nxt = ptr;
      s       = 0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         s = int'(ptr) + k;
         if (s >= N) s = s - N;
         idx = PW'(s);
         if (req[idx]) begin
            if (!vld0) begin
               gnt0[idx] = 1'b1;
               vld0      = 1'b1;
               ptr_nxt   = PW'((s + 1) % N);
            end else if (!vld1) begin
               gnt1[idx] = 1'b1;
               vld1      = 1'b1;
               ptr_nxt   = PW'((s + 1) % N);
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares CDB0/CDB1 between N_REQ result producers. Up to two round-robin
//   grants per cycle; granted results appear, registered, on the cycle
//   after the transfer. Idle buses drive all-zero fields because
//   downstream forwarding matches tags without qualifying by valid.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : no grants this cycle, buses cleared and ptr = 0 next
//   bus (slave)     : req_* handshake in, req_ready / cdb_* out
//   stall_cnt       : denied-requester count (CDB_ARB_STATS_EN), else 0
//   Build option: define CDB_ARB_STATS_EN to include the stall counter.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   cdb_arbiter_if.slave  bus,
   output logic [31:0]   stall_cnt
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
   logic [N_REQ-1:0] gnt0, gnt1;
   logic             vld0, vld1;
   logic             arb_en;
   cdb_entry_t [1:0] cdb_d, cdb_q;

   rr_pick2 #(.N(N_REQ)) u_pick (
      .req     (bus.req_valid),
      .ptr     (ptr_q),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .vld0    (vld0),
      .vld1    (vld1),
      .ptr_nxt (ptr_nxt)
   );

   // Grants are suppressed while reset or flush is high.
   assign arb_en        = !reset && !flush;
   assign bus.req_ready = arb_en ? (gnt0 | gnt1) : '0;

   always_comb begin
      cdb_d = '0;
      ptr_d = arb_en ? ptr_nxt : '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_en && vld0 && gnt0[i])
            cdb_d[0] = '{1'b1, bus.req_result[i], bus.req_arn[i], bus.req_rrn[i]};
         if (arb_en && vld1 && gnt1[i])
            cdb_d[1] = '{1'b1, bus.req_result[i], bus.req_arn[i], bus.req_rrn[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cdb_q <= '0;
         ptr_q <= '0;
      end else begin
         cdb_q <= cdb_d;
         ptr_q <= ptr_d;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_bus
      assign bus.cdb_valid[k]  = cdb_q[k].valid;
      assign bus.cdb_result[k] = cdb_q[k].result;
      assign bus.cdb_arn[k]    = cdb_q[k].arn;
      assign bus.cdb_rrn[k]    = cdb_q[k].rrn;
   end

`ifdef CDB_ARB_STATS_EN
   logic [31:0]      stall_cnt_q, stall_cnt_d;
   logic [N_REQ-1:0] denied;
   logic [32:0]      stall_sum;

   // Counts every valid requester left without a grant, saturating.
   always_comb begin
      denied      = bus.req_valid & ~bus.req_ready;
      stall_sum   = {1'b0, stall_cnt_q} + 33'(popcount8(8'(denied)));
      stall_cnt_d = stall_sum[32] ? '1 : stall_sum[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter with N_REQ = 4. Each step drives the
//   request vector, checks req_ready against the expected grant indices,
//   queues the expected CDB beats and compares them after the clock edge.
//   Build option: CDB_ARB_STATS_EN enables the stall_cnt check.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [31:0] stall_cnt;

   cdb_arbiter_if #(.N_REQ(N)) bus ();

   cdb_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [N-1:0][XLEN-1:0]  dres;
   logic [N-1:0][ARN_W-1:0] darn;
   logic [N-1:0][RRN_W-1:0] drrn;

   cdb_entry_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_data();
      bus.req_result = dres;
      bus.req_arn    = darn;
      bus.req_rrn    = drrn;
   endtask

   task automatic refresh(input int i);
      dres[i] = $urandom;
      darn[i] = ARN_W'($urandom);
      drrn[i] = RRN_W'($urandom);
   endtask

   task automatic compare_bus(input string tag);
      cdb_entry_t e, o;
      for (int k = 0; k < 2; k++) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            o = '{bus.cdb_valid[k], bus.cdb_result[k], bus.cdb_arn[k], bus.cdb_rrn[k]};
            chk($sformatf("%s_bus%0d", tag, k), 64'(o), 64'(e));
         end
      end
   endtask

   // e0/e1: requester expected on bus0/bus1 (-1 = none).
   task automatic step(input string tag, input logic [N-1:0] v, input logic fl,
                       input int e0, input int e1);
      logic [N-1:0] er;
      cdb_entry_t   x0, x1;
      drive_data();
      bus.req_valid = v;
      flush         = fl;
      #1;
      er = '0; x0 = '0; x1 = '0;
      if (e0 >= 0) begin er[e0] = 1'b1; x0 = '{1'b1, dres[e0], darn[e0], drrn[e0]}; end
      if (e1 >= 0) begin er[e1] = 1'b1; x1 = '{1'b1, dres[e1], darn[e1], drrn[e1]}; end
      chk({tag, "_ready"}, 64'(bus.req_ready), 64'(er));
      sb.push_back(x0);
      sb.push_back(x1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      compare_bus(tag);
      if (e0 >= 0) refresh(e0);
      if (e1 >= 0) refresh(e1);
   endtask

   task automatic reset_step(input string tag, input logic [N-1:0] v);
      drive_data();
      reset         = 1'b1;
      bus.req_valid = v;
      #1;
      chk({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
      sb.push_back('0);
      sb.push_back('0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      compare_bus(tag);
      chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.req_valid = '0;
      for (int i = 0; i < N; i++) refresh(i);
      drive_data();

      reset_step("rst", 4'b1111);

      step("idle0", 4'b0000, 1'b0, -1, -1);
      step("idle1", 4'b0000, 1'b0, -1, -1);

      step("p1011", 4'b1011, 1'b0, 0, 1);     // ptr -> 2
      step("rr_a",  4'b1111, 1'b0, 2, 3);     // ptr -> 0
      step("rr_b",  4'b1111, 1'b0, 0, 1);     // ptr -> 2
      step("rr_c",  4'b1111, 1'b0, 2, 3);     // ptr -> 0

      dres[2] = 32'hDEADBEEF; darn[2] = 5'd7; drrn[2] = 6'd33;
      step("single", 4'b0100, 1'b0, 2, -1);   // ptr -> 3

      step("flush", 4'b1111, 1'b1, -1, -1);   // ptr -> 0
      step("post_flush", 4'b1111, 1'b0, 0, 1); // ptr -> 2

      step("wrap_a", 4'b1001, 1'b0, 3, 0);    // ptr -> 1
      step("wrap_b", 4'b0001, 1'b0, 0, -1);   // ptr -> 1
      step("wrap_c", 4'b0011, 1'b0, 1, 0);    // last grant 0 -> ptr 1
      step("wrap_d", 4'b1000, 1'b0, 3, -1);   // ptr -> 0
      step("mid",    4'b1110, 1'b0, 1, 2);    // ptr -> 3

      reset_step("rst_mid", 4'b1111);          // ptr -> 0
      step("post_rst", 4'b0110, 1'b0, 1, 2);  // ptr -> 3
      reset_step("rst2", 4'b0000);             // ptr -> 0, stall cleared

      for (int c = 0; c < 10; c++) begin
         if (c % 2 == 0) step($sformatf("stat%0d", c), 4'b1111, 1'b0, 0, 1);
         else            step($sformatf("stat%0d", c), 4'b1111, 1'b0, 2, 3);
      end
      bus.req_valid = '0;
      #1;
`ifdef CDB_ARB_STATS_EN
      chk("stall_cnt", 64'(stall_cnt), 64'd20);
`else
      chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif

      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
